instr_encoder_loader: RTL and testbench
=======================================

Name: instr_encoder_loader

Overview:
- Inverse of the instruction decoder: takes decoded instruction fields over a valid/ready stream and packs each into a 32-bit instruction word.
- Writes packed words sequentially into instruction memory through a single write port.
- Used by the testbench and boot path to load programs into the processor's instruction memory.
- Terminates on HALT or on memory full.

Parameters:
- ADDR_W, 10, instruction memory address width in words.
- BASE_ADDR, 0, first word address written after start.

Ports:
- clk  input  1  system clock, all logic on rising edge.
- rst  input  1  synchronous, active-high reset.
- start  input  1  one-cycle pulse that begins a load session.
- in_valid  input  1  field bundle valid.
- in_ready  output  1  encoder can accept a bundle this cycle.
- opcode  input  6  instruction opcode.
- rs  input  5  source register.
- rt  input  5  target register.
- rd  input  5  destination register; used only when opcode is 000000.
- shamt  input  5  shift amount; used only when opcode is 000000.
- funct  input  6  function code; used only when opcode is 000000.
- imm  input  32  immediate; bits [15:0] are encoded.
- mem_we  output  1  instruction memory write enable.
- mem_addr  output  ADDR_W  write address.
- mem_wdata  output  32  encoded instruction word.
- busy  output  1  high in LOAD.
- done  output  1  session complete; held until the next start.
- count  output  ADDR_W+1  words written in the current session.
- overflow  output  1  memory filled before a HALT was written.

Behaviour:
- Clock and reset: one clock (clk); reset rst is synchronous and active-high.
- Reset state: state IDLE, write pointer = BASE_ADDR, count = 0, halt_seen = 0.
  - All outputs 0 on reset, including mem_we, mem_addr, mem_wdata, done, busy, overflow and in_ready.
  - Reset mid-session drops any pending write: mem_we is 0 in the cycle after reset.
- States: IDLE, LOAD, DONE.
  - IDLE: in_ready = 0. start -> LOAD; clears count, done, overflow, halt_seen; pointer = BASE_ADDR. in_valid arriving with start is ignored.
  - LOAD: start is ignored. Exit to DONE is defined under Termination.
  - DONE: done = 1, in_ready = 0. start -> LOAD with the same clearing as from IDLE.
- in_ready (combinational): (state == LOAD) && !halt_seen && !full, where full = count has reached 2^ADDR_W - BASE_ADDR.
- Acceptance and write timing:
  - A bundle is accepted when in_valid && in_ready in cycle N.
  - In cycle N+1: mem_we = 1 for exactly one cycle, mem_addr = pointer, mem_wdata = encoded word. Pointer and count increment in that same cycle.
  - Back-to-back acceptance sustains one write per cycle.
  - mem_addr and mem_wdata hold their last values when mem_we = 0.
- Encoding:
  - Opcode 000000 (R-type): {opcode, rs, rt, rd, shamt, funct}.
  - Opcode 010110 (HALT), 010111 (NOP), 011000 (RET): {opcode, 26'b0}; all other fields are ignored.
  - Opcode 010010 (MOVE): {opcode, rs, rt, 16'b0}; imm is ignored.
  - All other opcodes (I-type): {opcode, rs, rt, imm[15:0]}.
- Termination:
  - Accepting a HALT sets halt_seen immediately, so in_ready drops in cycle N+1. After the HALT write in N+1, state -> DONE in N+2.
  - When the last address (2^ADDR_W - 1) is written with a non-HALT word: overflow = 1, state -> DONE. If that last word is a HALT, overflow stays 0.
- Pointer never wraps; no write occurs beyond the last address.
- count is the number of words written, including the HALT.

Optional Feature:
- Macro: IMM_RANGE_CHECK_EN.
- Defined:
  - Adds output imm_err (1 bit), cleared on rst and on start.
  - imm_err is set sticky when an accepted I-type bundle (not MOVE, R-type, HALT, NOP or RET) has imm[31:16] != {16{imm[15]}}.
  - The word is still written, truncated to imm[15:0].
- Not defined: no imm_err port; truncation is silent.

Test Plan:
- R-type: start; opcode 000000, rs=1, rt=2, rd=3, shamt=0, funct=0x20 -> next cycle mem_we=1, mem_addr=0, mem_wdata=0x00221820, count=1.
- I-type with sign: opcode 000001, rs=4, rt=5, imm=0xFFFFFFFF -> mem_wdata=0x0485FFFF. With IMM_RANGE_CHECK_EN, imm=0x00012345 -> imm_err=1.
- MOVE and HALT stream: back-to-back MOVE (rs=7, rt=8, imm=0x1234) then HALT (rs=31, imm=0xFFFF) ->
  - writes 0x48E80000 at addr 0 and 0x58000000 at addr 1 on consecutive cycles;
  - in_ready=0 after HALT acceptance; done=1, count=2, overflow=0.
- Overflow: ADDR_W=2, four NOP bundles -> addresses 0..3 written with 0x5C000000; overflow=1, done=1, count=4; in_ready=0 afterward.
- Reset mid-session: assert rst in the cycle a bundle is accepted -> mem_we=0 the next cycle; all outputs 0; start then restarts at addr BASE_ADDR.
- start ignored during LOAD; start in DONE clears done and count and writes the next word at BASE_ADDR.

Source files
------------

// File: rtl/instr_encoder_loader.sv
// Packs decoded instruction fields into 32-bit words and streams them into instruction memory.
// Optional macro IMM_RANGE_CHECK_EN adds a sticky imm_err flag for I-type immediates that do not fit 16 bits.
module instr_encoder_loader #(
    parameter int ADDR_W    = 10,
    parameter int BASE_ADDR = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [5:0]        opcode,
    input  logic [4:0]        rs,
    input  logic [4:0]        rt,
    input  logic [4:0]        rd,
    input  logic [4:0]        shamt,
    input  logic [5:0]        funct,
    input  logic [31:0]       imm,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    output logic              busy,
    output logic              done,
    output logic [ADDR_W:0]   count,
    output logic              overflow
`ifdef IMM_RANGE_CHECK_EN
    ,
    output logic              imm_err
`endif
);
    localparam logic [5:0] OP_R    = 6'b000000;
    localparam logic [5:0] OP_MOVE = 6'b010010;
    localparam logic [5:0] OP_HALT = 6'b010110;
    localparam logic [5:0] OP_NOP  = 6'b010111;
    localparam logic [5:0] OP_RET  = 6'b011000;

    localparam logic [ADDR_W:0]   CAP  = (ADDR_W+1)'((2**ADDR_W) - BASE_ADDR);
    localparam logic [ADDR_W-1:0] BASE = ADDR_W'(BASE_ADDR);
    localparam logic [ADDR_W-1:0] LAST = '1;

    typedef enum logic [1:0] {IDLE, LOAD, DONE} state_t;

    state_t            state, state_nxt;
    logic [ADDR_W-1:0] ptr;
    logic              halt_seen;
    logic              full;
    logic              acc;
    logic              sess_start;
    logic              term;
    logic [31:0]       enc;

    assign full       = (count >= CAP);
    assign in_ready   = (state == LOAD) && !halt_seen && !full;
    assign acc        = in_valid && in_ready;
    assign sess_start = start && (state != LOAD);
    // The write cycle right after the final accept (HALT or last address) ends the session.
    assign term       = (state == LOAD) && mem_we && (halt_seen || full);
    assign busy       = (state == LOAD);
    assign done       = (state == DONE);

    always_comb begin
        case (opcode)
            OP_R:                    enc = {opcode, rs, rt, rd, shamt, funct};
            OP_HALT, OP_NOP, OP_RET: enc = {opcode, 26'b0};
            OP_MOVE:                 enc = {opcode, rs, rt, 16'b0};
            default:                 enc = {opcode, rs, rt, imm[15:0]};
        endcase
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = LOAD;
            LOAD:    if (term)  state_nxt = DONE;
            DONE:    if (start) state_nxt = LOAD;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            ptr       <= BASE;
            count     <= '0;
            halt_seen <= 1'b0;
            overflow  <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
        end else begin
            state  <= state_nxt;
            mem_we <= acc;
            if (sess_start) begin
                ptr       <= BASE;
                count     <= '0;
                halt_seen <= 1'b0;
                overflow  <= 1'b0;
            end else if (acc) begin
                mem_addr  <= ptr;
                mem_wdata <= enc;
                count     <= count + (ADDR_W+1)'(1);
                // Saturate at the last address; full blocks any further accept.
                if (ptr != LAST) ptr <= ptr + ADDR_W'(1);
                if (opcode == OP_HALT) halt_seen <= 1'b1;
            end
            if (term) overflow <= !halt_seen;
        end
    end

`ifdef IMM_RANGE_CHECK_EN
    logic is_itype;
    logic imm_wide;
    assign is_itype = !(opcode inside {OP_R, OP_MOVE, OP_HALT, OP_NOP, OP_RET});
    assign imm_wide = (imm[31:16] != {16{imm[15]}});

    always_ff @(posedge clk) begin
        if (rst)                             imm_err <= 1'b0;
        else if (sess_start)                 imm_err <= 1'b0;
        else if (acc && is_itype && imm_wide) imm_err <= 1'b1;
    end
`else
    logic unused_imm_hi;
    assign unused_imm_hi = ^imm[31:16];
`endif

endmodule

// File: tb/tb_instr_encoder_loader.sv
// Bench for instr_encoder_loader: constant vectors, directed multi-cycle sequences and a random
// stream checked every cycle against a session-level reference model.
module tb_instr_encoder_loader;
    localparam int ADDR_W    = 2;
    localparam int BASE_ADDR = 0;
    localparam int DEPTH     = 2**ADDR_W;

    logic              clk = 1'b0;
    logic              rst, start, in_valid, in_ready;
    logic [5:0]        opcode, funct;
    logic [4:0]        rs, rt, rd, shamt;
    logic [31:0]       imm;
    logic              mem_we, busy, done, overflow;
    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_wdata;
    logic [ADDR_W:0]   count;
`ifdef IMM_RANGE_CHECK_EN
    logic              imm_err;
`endif

    always #5 clk = ~clk;

    instr_encoder_loader #(.ADDR_W(ADDR_W), .BASE_ADDR(BASE_ADDR)) dut (
        .clk(clk), .rst(rst), .start(start), .in_valid(in_valid), .in_ready(in_ready),
        .opcode(opcode), .rs(rs), .rt(rt), .rd(rd), .shamt(shamt), .funct(funct), .imm(imm),
        .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .busy(busy), .done(done), .count(count), .overflow(overflow)
`ifdef IMM_RANGE_CHECK_EN
        , .imm_err(imm_err)
`endif
    );

    int n_pass = 0;
    int n_total = 0;

    function automatic void check(string name, logic [31:0] act, logic [31:0] exp);
        n_total++;
        if (act !== exp) $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        else n_pass++;
    endfunction

    // Reference model: a session is idle(0) / loading(1) / done(2); words written so far = m_cnt.
    int          m_phase, m_cnt;
    bit          m_halt, m_ovf, m_term, m_we, m_err;
    logic [31:0] m_addr, m_wdata;

    function automatic bit m_rdy();
        return (m_phase == 1) && !m_halt && (BASE_ADDR + m_cnt < DEPTH);
    endfunction

    function automatic logic [31:0] ref_enc(logic [5:0] op, logic [4:0] a, logic [4:0] b,
                                            logic [4:0] c, logic [4:0] s, logic [5:0] f,
                                            logic [31:0] i);
        logic [31:0] w;
        w = 32'(op) << 26;
        case (op)
            6'h00:               w = w | (32'(a) << 21) | (32'(b) << 16) | (32'(c) << 11) | (32'(s) << 6) | 32'(f);
            6'h16, 6'h17, 6'h18: ;
            6'h12:               w = w | (32'(a) << 21) | (32'(b) << 16);
            default:             w = w | (32'(a) << 21) | (32'(b) << 16) | (i & 32'h0000FFFF);
        endcase
        return w;
    endfunction

    function automatic void model_edge();
        bit acc;
        int si;
        acc = in_valid && m_rdy();
        if (rst) begin
            m_phase = 0; m_cnt = 0; m_halt = 0; m_ovf = 0; m_term = 0;
            m_we = 0; m_addr = 0; m_wdata = 0; m_err = 0;
            return;
        end
        m_we = 0;
        if (m_phase == 1 && m_term) begin
            m_phase = 2; m_ovf = !m_halt; m_term = 0;
        end else if (m_phase != 1 && start) begin
            m_phase = 1; m_cnt = 0; m_halt = 0; m_ovf = 0; m_err = 0;
        end else if (acc) begin
            m_we    = 1;
            m_addr  = 32'(BASE_ADDR + m_cnt);
            m_wdata = ref_enc(opcode, rs, rt, rd, shamt, funct, imm);
            m_cnt++;
            si = $signed(imm);
            if (!(opcode inside {6'h00, 6'h12, 6'h16, 6'h17, 6'h18}) && (si > 32767 || si < -32768))
                m_err = 1;
            if (opcode == 6'h16) begin
                m_halt = 1; m_term = 1;
            end else if (BASE_ADDR + m_cnt == DEPTH) begin
                m_term = 1;
            end
        end
    endfunction

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
        check("mem_we",   32'(mem_we),   32'(m_we));
        check("mem_addr", 32'(mem_addr), m_addr);
        check("mem_wdata", mem_wdata,    m_wdata);
        check("in_ready", 32'(in_ready), 32'(m_rdy()));
        check("busy",     32'(busy),     32'(m_phase == 1));
        check("done",     32'(done),     32'(m_phase == 2));
        check("count",    32'(count),    32'(m_cnt));
        check("overflow", 32'(overflow), 32'(m_ovf));
`ifdef IMM_RANGE_CHECK_EN
        check("imm_err",  32'(imm_err),  32'(m_err));
`endif
    endtask

    task automatic bundle(logic [5:0] op, logic [4:0] a, logic [4:0] b, logic [4:0] c,
                          logic [4:0] s, logic [5:0] f, logic [31:0] i);
        opcode = op; rs = a; rt = b; rd = c; shamt = s; funct = f; imm = i;
    endtask

    task automatic new_session();
        rst = 1; start = 0; in_valid = 0; step();
        rst = 0; start = 1; step();
        start = 0;
    endtask

    typedef struct {
        logic [5:0]  op;
        logic [4:0]  rs, rt, rd, sh;
        logic [5:0]  fn;
        logic [31:0] imm;
        logic [31:0] exp;
        bit          exp_err;
    } vec_t;

    vec_t vecs[9];

    function automatic logic [5:0] rand_op();
        int r;
        r = $urandom_range(0, 9);
        case (r)
            0, 1:    return 6'h00;
            2:       return 6'h16;
            3:       return 6'h17;
            4:       return 6'h18;
            5:       return 6'h12;
            default: return 6'($urandom());
        endcase
    endfunction

    initial begin
        vecs[0] = '{6'h00, 5'd1,  5'd2,  5'd3,  5'd0, 6'h20, 32'hDEADBEEF, 32'h00221820, 1'b0};
        vecs[1] = '{6'h01, 5'd4,  5'd5,  5'd0,  5'd0, 6'h00, 32'hFFFFFFFF, 32'h0485FFFF, 1'b0};
        vecs[2] = '{6'h01, 5'd4,  5'd5,  5'd0,  5'd0, 6'h00, 32'h00012345, 32'h04852345, 1'b1};
        vecs[3] = '{6'h12, 5'd7,  5'd8,  5'd1,  5'd1, 6'h3F, 32'h7FFF1234, 32'h48E80000, 1'b0};
        vecs[4] = '{6'h16, 5'd31, 5'd0,  5'd0,  5'd0, 6'h00, 32'h0000FFFF, 32'h58000000, 1'b0};
        vecs[5] = '{6'h17, 5'd3,  5'd9,  5'd4,  5'd2, 6'h11, 32'h12345678, 32'h5C000000, 1'b0};
        vecs[6] = '{6'h18, 5'd5,  5'd6,  5'd7,  5'd8, 6'h09, 32'hFFFF0000, 32'h60000000, 1'b0};
        vecs[7] = '{6'h23, 5'd29, 5'd31, 5'd0,  5'd0, 6'h00, 32'hFFFF8000, 32'h8FBF8000, 1'b0};
        vecs[8] = '{6'h00, 5'd0,  5'd9,  5'd10, 5'd4, 6'h00, 32'hFFFF0000, 32'h00095100, 1'b0};

        rst = 1; start = 0; in_valid = 0;
        bundle(6'h00, 5'd0, 5'd0, 5'd0, 5'd0, 6'h00, 32'h0);
        step(); step();
        check("reset_we",    32'(mem_we),    32'h0);
        check("reset_wdata", mem_wdata,      32'h0);
        check("reset_ready", 32'(in_ready),  32'h0);
        check("reset_done",  32'(done),      32'h0);
        rst = 0; step();

        // Start pulse with in_valid high in IDLE: the bundle must be ignored.
        start = 1; in_valid = 1; step();
        start = 0; in_valid = 0;
        check("idle_valid_ignored", 32'(mem_we), 32'h0);

        foreach (vecs[k]) begin
            new_session();
            bundle(vecs[k].op, vecs[k].rs, vecs[k].rt, vecs[k].rd, vecs[k].sh, vecs[k].fn, vecs[k].imm);
            in_valid = 1; step(); in_valid = 0;
            check($sformatf("vec%0d_we", k),    32'(mem_we),   32'h1);
            check($sformatf("vec%0d_addr", k),  32'(mem_addr), 32'(BASE_ADDR));
            check($sformatf("vec%0d_wdata", k), mem_wdata,     vecs[k].exp);
            check($sformatf("vec%0d_count", k), 32'(count),    32'h1);
`ifdef IMM_RANGE_CHECK_EN
            check($sformatf("vec%0d_imm_err", k), 32'(imm_err), 32'(vecs[k].exp_err));
`endif
        end

        // MOVE then HALT back to back; a trailing NOP must not be taken.
        new_session();
        bundle(6'h12, 5'd7, 5'd8, 5'd0, 5'd0, 6'h00, 32'h1234); in_valid = 1; step();
        check("mh_addr0",  32'(mem_addr), 32'h0);
        check("mh_data0",  mem_wdata,     32'h48E80000);
        bundle(6'h16, 5'd31, 5'd0, 5'd0, 5'd0, 6'h00, 32'hFFFF); step();
        check("mh_we1",    32'(mem_we),   32'h1);
        check("mh_addr1",  32'(mem_addr), 32'h1);
        check("mh_data1",  mem_wdata,     32'h58000000);
        check("mh_ready",  32'(in_ready), 32'h0);
        bundle(6'h17, 5'd0, 5'd0, 5'd0, 5'd0, 6'h00, 32'h0); step();
        in_valid = 0;
        check("mh_noextra", 32'(mem_we),  32'h0);
        check("mh_done",   32'(done),     32'h1);
        check("mh_count",  32'(count),    32'h2);
        check("mh_ovf",    32'(overflow), 32'h0);

        // Four NOPs fill the memory without a HALT.
        new_session();
        bundle(6'h17, 5'd1, 5'd1, 5'd1, 5'd1, 6'h01, 32'h1); in_valid = 1;
        for (int i = 0; i < DEPTH; i++) begin
            step();
            check($sformatf("ov_addr%0d", i), 32'(mem_addr), 32'(i));
            check($sformatf("ov_data%0d", i), mem_wdata,     32'h5C000000);
        end
        check("ov_ready", 32'(in_ready), 32'h0);
        step(); in_valid = 0;
        check("ov_flag",  32'(overflow), 32'h1);
        check("ov_done",  32'(done),     32'h1);
        check("ov_count", 32'(count),    32'(DEPTH));
        check("ov_ready2", 32'(in_ready), 32'h0);

        // Start from DONE clears the session; a start during LOAD is ignored.
        start = 1; step(); start = 0;
        check("rs_done",  32'(done),  32'h0);
        check("rs_count", 32'(count), 32'h0);
        bundle(6'h01, 5'd4, 5'd5, 5'd0, 5'd0, 6'h00, 32'hFFFFFFFF); in_valid = 1; step();
        check("rs_addr",  32'(mem_addr), 32'(BASE_ADDR));
        start = 1; step(); start = 0; in_valid = 0;
        check("ld_start_addr",  32'(mem_addr), 32'(BASE_ADDR + 1));
        check("ld_start_count", 32'(count),    32'h2);

        // Reset in the same cycle as an accept drops the write.
        in_valid = 1; rst = 1; step(); rst = 0; in_valid = 0;
        check("mr_we",    32'(mem_we),   32'h0);
        check("mr_addr",  32'(mem_addr), 32'h0);
        check("mr_count", 32'(count),    32'h0);
        check("mr_busy",  32'(busy),     32'h0);
        start = 1; step(); start = 0;
        bundle(6'h17, 5'd0, 5'd0, 5'd0, 5'd0, 6'h00, 32'h0); in_valid = 1; step(); in_valid = 0;
        check("mr_restart_addr", 32'(mem_addr), 32'(BASE_ADDR));
        check("mr_restart_we",   32'(mem_we),   32'h1);

        // Random stream against the model.
        for (int c = 0; c < 3000; c++) begin
            rst      = ($urandom_range(0, 63) == 0);
            start    = ($urandom_range(0, 7) == 0);
            in_valid = ($urandom_range(0, 3) != 0);
            bundle(rand_op(), 5'($urandom()), 5'($urandom()), 5'($urandom()), 5'($urandom()),
                   6'($urandom()),
                   ($urandom_range(0, 1) == 1) ? $urandom() : {{16{1'b1}}, 16'($urandom())});
            step();
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
